pc_step_sequencer: RTL
======================

// Module: pc_step_sequencer
// PURPOSE
//  Drives the single-step / free-run front end of the single-cycle core.
//  - Turns the raw nextInstructionButton into one clean step pulse per press; switch selects free-run.
//  - Owns the PC: consumes the instruction decoder's writePc/jumpEnable plus the ALU zero flag.
//  - Latches halt when a step is issued with writePc=0 (stop instruction).
// PARAMETERS
//  PC_W             4    PC / instruction-memory address width
//  DEBOUNCE_CYCLES  16   consecutive stable synced samples needed to accept a level change (>=2)
//  CNT_W            8    width of executed-step counter
// PORTS
//  clk                    in   1       system clock, rising edge
//  reset                  in   1       asynchronous, active-high
//  nextInstructionButton  in   1       raw, bouncy, asynchronous push button
//  switch                 in   1       raw asynchronous run-mode switch (1 = free-run)
//  writePc                in   1       decoder: 1 = advance PC this step, 0 = stop
//  jumpEnable             in   1       decoder: current instruction is branch-if-equal
//  aluZero                in   1       ALU result zero (branch condition)
//  branchTarget           in   PC_W    absolute branch target from instruction field
//  stepPulse              out  1       one-cycle enable: commit reg/mem writes + PC this cycle
//  pc                     out  PC_W    current instruction address
//  halted                 out  1       sticky stop flag
//  stepCount              out  CNT_W   number of committed steps, saturating
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-debounce): pc=0, halted=0, stepCount=0, stepPulse=0,
//   synchronisers=0, debounced level=0, debounce counter=0, FSM=IDLE.
//  Sync: button and switch each pass a 2-FF synchroniser; only synced values used.
//  Debounce (button only): counter clears when synced==debounced level; increments while different;
//   when it reaches DEBOUNCE_CYCLES-1 and still differs, debounced level toggles, counter clears.
//  FSM (button path): IDLE -> PRESS_DB on synced=1; PRESS_DB -> IDLE if bounce clears counter;
//   PRESS_DB -> HELD on debounced 0->1 (emit step request); HELD -> REL_DB on synced=0;
//   REL_DB -> HELD if bounce; REL_DB -> IDLE on debounced 1->0. Exactly one request per press;
//   holding the button produces no further requests.
//  stepPulse is registered. stepPulse=1 in cycle N+1 when:
//   - switch_sync=0: button request in cycle N and !halted;
//   - switch_sync=1: every cycle while !halted; button requests dropped (FSM still tracks).
//  Latency clean press -> stepPulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//  On a cycle with stepPulse=1 (edge at end of that cycle):
//   - writePc=0: halted<=1, pc held, stepCount held.
//   - writePc=1, jumpEnable&aluZero: pc<=branchTarget.
//   - writePc=1, otherwise: pc<=pc+1, mod 2^PC_W (all-ones wraps to 0).
//   - writePc=1: stepCount<=stepCount+1, saturating at 2^CNT_W-1.
//  halted: sticky; only reset clears; halted forces stepPulse=0 from the next cycle on.
//  Switch toggled mid-debounce: any button request pending is governed by switch_sync at cycle N.
//  No outputs change without stepPulse except via reset.
// TESTING
//  1 Clean press (DEBOUNCE_CYCLES=16), button high 40 cycles, writePc=1 -> exactly one stepPulse
//    19 cycles after press; pc 0->1; stepCount=1.
//  2 Bouncy press (toggle every 3 cycles for 30 cycles, then stable high) -> one stepPulse only;
//    release with bounce -> no pulse.
//  3 switch=1, writePc=1, 20 cycles, PC_W=4 -> stepPulse every cycle; pc wraps 15->0.
//    stepCount increments each cycle.
//  4 Branch: jumpEnable=1, aluZero=1, branchTarget=4'hA, one step -> pc=A;
//    with aluZero=0 -> pc=pc+1.
//  5 Halt: switch=1, writePc=0 at pc=5 -> one stepPulse, halted=1, pc stays 5.
//    No further pulses despite switch/button.
//  6 Reset asserted mid PRESS_DB and while halted -> all outputs 0 immediately (async).
//    Next clean press yields pulse after full latency.

Source files
------------

// File: rtl/pc_step_sequencer.sv
// pc_step_sequencer: debounced single-step / free-run front end owning the PC, halt flag and step counter
module pc_step_sequencer #(
  parameter int PC_W = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            nextInstructionButton,
  input  logic            switch,
  input  logic            writePc,
  input  logic            jumpEnable,
  input  logic            aluZero,
  input  logic [PC_W-1:0] branchTarget,
  output logic            stepPulse,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [CNT_W-1:0] stepCount
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;
  state_t state, state_n;
  logic btn_m, btn_s, sw_m, sw_s, db, req, halt_n, pulse_n;
  logic [DW-1:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {btn_m, btn_s, sw_m, sw_s} <= '0;
      db <= 1'b0;
      cnt <= '0;
      state <= IDLE;
    end else begin
      {btn_s, btn_m} <= {btn_m, nextInstructionButton};
      {sw_s, sw_m} <= {sw_m, switch};
      state <= state_n;
      cnt <= (btn_s == db || cnt == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : cnt + 1'b1;
      db <= (btn_s != db && cnt == DW'(DEBOUNCE_CYCLES - 1)) ? ~db : db;
    end
  end
  // A request is issued in the single cycle PRESS_DB observes the debounced rise
  always_comb begin
    state_n = state;
    req = 1'b0;
    case (state)
      IDLE:     state_n = btn_s ? PRESS_DB : IDLE;
      PRESS_DB: begin
        req = db;
        state_n = db ? HELD : (btn_s ? PRESS_DB : IDLE);
      end
      HELD:     state_n = btn_s ? HELD : REL_DB;
      REL_DB:   state_n = !db ? IDLE : (btn_s ? HELD : REL_DB);
      default:  state_n = IDLE;
    endcase
  end
  // The halting step must also suppress the pulse that would follow it
  assign halt_n = halted | (stepPulse & ~writePc);
  assign pulse_n = ~halt_n & (sw_s | req);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stepPulse <= 1'b0;
      pc <= '0;
      halted <= 1'b0;
      stepCount <= '0;
    end else begin
      stepPulse <= pulse_n;
      halted <= halt_n;
      if (stepPulse && writePc) begin
        pc <= (jumpEnable && aluZero) ? branchTarget : pc + 1'b1;
        stepCount <= (stepCount == '1) ? stepCount : stepCount + 1'b1;
      end
    end
  end
endmodule
